time_param_bank: RTL and testbench

Parametrised, reprogrammable bank of traffic-light time parameters with an integrated interval countdown. It replaces the fixed four-entry parameter store. NUM_PARAMS values of VALUE_W bits are held, initialised to compile-time defaults and overwritten at run time from the switch inputs. The block also times the selected interval against a 1 Hz tick, so the controller FSM only issues Start and waits for Expired.

---
 rtl/time_param_bank_pkg.sv | 15 +
 rtl/time_param_bank_if.sv | 29 ++
 rtl/time_param_bank_countdown.sv | 51 +++++
 rtl/time_param_bank.sv | 78 +++++++
 tb/tb_time_param_bank.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/time_param_bank_pkg.sv
// rtl/time_param_bank_pkg.sv - shared constants and countdown state type for time_param_bank
package time_param_pkg;

  localparam logic [3:0] T_BASE_DEF  = 4'd6;
  localparam logic [3:0] T_EXT_DEF   = 4'd3;
  localparam logic [3:0] T_YEL_DEF   = 4'd2;
  localparam logic [3:0] T_SPARE_DEF = 4'd4;

  localparam int IDX_BASE = 0;
  localparam int IDX_EXT  = 1;
  localparam int IDX_YEL  = 2;

  typedef enum logic {IDLE, RUN} cd_state_t;

endpackage

// File: rtl/time_param_bank_if.sv
// rtl/time_param_bank_if.sv - reprogram/read/countdown signal bundle for time_param_bank
interface time_param_bank_if #(
  parameter int NUM_PARAMS = 4,
  parameter int VALUE_W    = 4
);
  localparam int SEL_W = $clog2(NUM_PARAMS);

  logic               Sync_Reprogram;
  logic [SEL_W-1:0]   Selector;
  logic [VALUE_W-1:0] Time_Value;
  logic [SEL_W-1:0]   Interval;
  logic               Start;
  logic               Tick;
  logic [VALUE_W-1:0] Value;
  logic [VALUE_W-1:0] Remaining;
  logic               Busy;
  logic               Expired;
  logic               Prog_Err;

  modport master (
    output Sync_Reprogram, Selector, Time_Value, Interval, Start, Tick,
    input  Value, Remaining, Busy, Expired, Prog_Err
  );

  modport slave (
    input  Sync_Reprogram, Selector, Time_Value, Interval, Start, Tick,
    output Value, Remaining, Busy, Expired, Prog_Err
  );
endinterface

// File: rtl/time_param_bank_countdown.sv
// rtl/time_param_bank_countdown.sv - interval countdown FSM driven by the 1 Hz tick
module interval_countdown
  import time_param_pkg::*;
#(
  parameter int VALUE_W = 4
) (
  input  logic               clk,
  input  logic               Sync_Reset_n,
  input  logic               load,
  input  logic [VALUE_W-1:0] load_val,
  input  logic               tick,
  output logic [VALUE_W-1:0] remaining,
  output logic               busy,
  output logic               expired
);

  cd_state_t state;

  always_ff @(posedge clk) begin
    if (!Sync_Reset_n) begin
      state     <= IDLE;
      remaining <= '0;
      busy      <= 1'b0;
      expired   <= 1'b0;
    end else begin
      expired <= 1'b0;
      // a load always wins over a coincident tick
      if (load) begin
        remaining <= load_val;
        if (load_val != '0) begin
          state <= RUN;
          busy  <= 1'b1;
        end else begin
          state   <= IDLE;
          busy    <= 1'b0;
          expired <= 1'b1;
        end
      end else if (state == RUN && tick) begin
        if (remaining > VALUE_W'(1)) begin
          remaining <= remaining - VALUE_W'(1);
        end else begin
          remaining <= '0;
          state     <= IDLE;
          busy      <= 1'b0;
          expired   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/time_param_bank.sv
// rtl/time_param_bank.sv - reprogrammable time parameter bank with countdown; TP_ZERO_GUARD_EN rejects zero writes
module time_param_bank
  import time_param_pkg::*;
#(
  parameter int NUM_PARAMS = 4,
  parameter int VALUE_W    = 4,
  parameter int SEL_W      = $clog2(NUM_PARAMS),
  parameter logic [NUM_PARAMS*VALUE_W-1:0] DEFAULT_VALUES =
    {T_SPARE_DEF, T_YEL_DEF, T_EXT_DEF, T_BASE_DEF}
) (
  input  logic              clk,
  input  logic              Sync_Reset_n,
  time_param_bank_if.slave  bus
);

  logic [VALUE_W-1:0] bank [NUM_PARAMS];
  logic               sel_ok;
  logic               int_ok;
  logic               wr_ok;
  logic [VALUE_W-1:0] rd_val;

`ifdef TP_ZERO_GUARD_EN
  for (genvar g = 0; g < NUM_PARAMS; g++) begin : g_def_chk
    if (DEFAULT_VALUES[g*VALUE_W +: VALUE_W] == '0) begin : g_bad
      $error("time_param_bank: zero default value not allowed with zero guard");
    end
  end
`endif

  always_comb begin
    sel_ok = int'(bus.Selector) < NUM_PARAMS;
    int_ok = int'(bus.Interval) < NUM_PARAMS;
`ifdef TP_ZERO_GUARD_EN
    wr_ok  = bus.Sync_Reprogram && sel_ok && (bus.Time_Value != '0);
`else
    wr_ok  = bus.Sync_Reprogram && sel_ok;
`endif
    // read sees the value being written on the same edge
    rd_val = '0;
    if (int_ok) begin
      if (wr_ok && bus.Selector == bus.Interval) begin
        rd_val = bus.Time_Value;
      end else begin
        rd_val = bank[bus.Interval];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!Sync_Reset_n) begin
      for (int i = 0; i < NUM_PARAMS; i++) begin
        bank[i] <= DEFAULT_VALUES[i*VALUE_W +: VALUE_W];
      end
      bus.Value    <= DEFAULT_VALUES[IDX_BASE*VALUE_W +: VALUE_W];
      bus.Prog_Err <= 1'b0;
    end else begin
      if (wr_ok) begin
        bank[bus.Selector] <= bus.Time_Value;
      end
      bus.Value    <= rd_val;
      bus.Prog_Err <= bus.Sync_Reprogram && !wr_ok;
    end
  end

  interval_countdown #(
    .VALUE_W (VALUE_W)
  ) u_countdown (
    .clk          (clk),
    .Sync_Reset_n (Sync_Reset_n),
    .load         (bus.Start && int_ok),
    .load_val     (rd_val),
    .tick         (bus.Tick),
    .remaining    (bus.Remaining),
    .busy         (bus.Busy),
    .expired      (bus.Expired)
  );

endmodule

// File: tb/tb_time_param_bank.sv
// tb/tb_time_param_bank.sv - self-checking bench for time_param_bank (4-entry and 3-entry instances)
module tb_time_param_bank;

`ifdef TP_ZERO_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  time_param_bank_if #(.NUM_PARAMS(4), .VALUE_W(4)) bus0 ();
  time_param_bank_if #(.NUM_PARAMS(3), .VALUE_W(4)) bus1 ();

  time_param_bank #(.NUM_PARAMS(4), .VALUE_W(4)) dut0 (
    .clk(clk), .Sync_Reset_n(rst_n), .bus(bus0.slave)
  );

  time_param_bank #(
    .NUM_PARAMS(3), .VALUE_W(4), .DEFAULT_VALUES({4'd2, 4'd3, 4'd6})
  ) dut1 (
    .clk(clk), .Sync_Reset_n(rst_n), .bus(bus1.slave)
  );

  int total = 0;
  int bad   = 0;

  bit       rp, st, tk;
  bit [1:0] sel, intv;
  bit [3:0] tv;

  // reference state: bank contents and the outputs each instance should show
  int nparam [2] = '{4, 3};
  int defv [2][4] = '{'{6, 3, 2, 4}, '{6, 3, 2, 0}};
  int mbank [2][4];
  int mval [2];
  int mrem [2];
  bit mbusy [2];
  bit mexp [2];
  bit mperr [2];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at %0t: got=%0d want=%0d", name, $time, act, exp);
    end
  endtask

  task automatic model_step(input int k);
    bit wok;
    if (!rst_n) begin
      for (int i = 0; i < nparam[k]; i++) mbank[k][i] = defv[k][i];
      mval[k] = defv[k][0];
      mrem[k] = 0; mbusy[k] = 0; mexp[k] = 0; mperr[k] = 0;
      return;
    end
    wok = rp && (int'(sel) < nparam[k]) && !(GUARD && tv == 0);
    mperr[k] = rp && !wok;
    if (wok) mbank[k][sel] = tv;
    mval[k] = (int'(intv) < nparam[k]) ? mbank[k][intv] : 0;
    mexp[k] = 0;
    if (st && int'(intv) < nparam[k]) begin
      mrem[k]  = mbank[k][intv];
      mbusy[k] = (mrem[k] != 0);
      mexp[k]  = (mrem[k] == 0);
    end else if (mbusy[k] && tk) begin
      mrem[k] = mrem[k] - 1;
      if (mrem[k] == 0) begin
        mbusy[k] = 0;
        mexp[k]  = 1;
      end
    end
  endtask

  task automatic cycle();
    bus0.Sync_Reprogram = rp; bus0.Selector = sel; bus0.Time_Value = tv;
    bus0.Interval = intv; bus0.Start = st; bus0.Tick = tk;
    bus1.Sync_Reprogram = rp; bus1.Selector = sel; bus1.Time_Value = tv;
    bus1.Interval = intv; bus1.Start = st; bus1.Tick = tk;
    @(posedge clk);
    #1;
    model_step(0);
    model_step(1);
    chk("value0", bus0.Value, mval[0]);
    chk("remaining0", bus0.Remaining, mrem[0]);
    chk("busy0", bus0.Busy, mbusy[0]);
    chk("expired0", bus0.Expired, mexp[0]);
    chk("prog_err0", bus0.Prog_Err, mperr[0]);
    chk("value1", bus1.Value, mval[1]);
    chk("remaining1", bus1.Remaining, mrem[1]);
    chk("busy1", bus1.Busy, mbusy[1]);
    chk("expired1", bus1.Expired, mexp[1]);
    chk("prog_err1", bus1.Prog_Err, mperr[1]);
  endtask

  task automatic step(input bit r, input bit p, input int s, input int v,
                      input int iv, input bit a, input bit t);
    rst_n = r; rp = p; sel = 2'(s); tv = 4'(v); intv = 2'(iv); st = a; tk = t;
    cycle();
  endtask

  typedef struct {
    bit r; bit p; int s; int v; int iv; bit a; bit t;
    int e_val; int e_rem; bit e_busy; bit e_exp;
  } vec_t;

  vec_t tbl [16];
  int   expcnt;

  initial begin
    rst_n = 1'b0; rp = 0; st = 0; tk = 0; sel = 0; intv = 0; tv = 0;

    tbl[0]  = '{0, 0, 0, 0, 0, 0, 0,  6, 0, 0, 0};
    tbl[1]  = '{1, 0, 0, 0, 0, 0, 0,  6, 0, 0, 0};
    tbl[2]  = '{1, 0, 0, 0, 1, 0, 0,  3, 0, 0, 0};
    tbl[3]  = '{1, 0, 0, 0, 2, 0, 0,  2, 0, 0, 0};
    tbl[4]  = '{1, 0, 0, 0, 3, 0, 0,  4, 0, 0, 0};
    tbl[5]  = '{1, 1, 1, 5, 1, 0, 0,  5, 0, 0, 0};
    tbl[6]  = '{0, 0, 0, 0, 1, 0, 0,  6, 0, 0, 0};
    tbl[7]  = '{1, 0, 0, 0, 1, 0, 0,  3, 0, 0, 0};
    tbl[8]  = '{1, 0, 0, 0, 2, 1, 0,  2, 2, 1, 0};
    tbl[9]  = '{1, 0, 0, 0, 2, 0, 1,  2, 1, 1, 0};
    tbl[10] = '{1, 0, 0, 0, 2, 0, 1,  2, 0, 0, 1};
    tbl[11] = '{1, 0, 0, 0, 2, 0, 0,  2, 0, 0, 0};
    tbl[12] = '{1, 0, 0, 0, 0, 1, 1,  6, 6, 1, 0};
    tbl[13] = '{1, 0, 0, 0, 0, 0, 1,  6, 5, 1, 0};
    tbl[14] = '{1, 0, 0, 0, 0, 1, 1,  6, 6, 1, 0};
    tbl[15] = '{0, 0, 0, 0, 0, 0, 0,  6, 0, 0, 0};

    for (int i = 0; i < 16; i++) begin
      step(tbl[i].r, tbl[i].p, tbl[i].s, tbl[i].v, tbl[i].iv, tbl[i].a, tbl[i].t);
      chk("tbl_value", bus0.Value, tbl[i].e_val);
      chk("tbl_remaining", bus0.Remaining, tbl[i].e_rem);
      chk("tbl_busy", bus0.Busy, tbl[i].e_busy);
      chk("tbl_expired", bus0.Expired, tbl[i].e_exp);
      chk("tbl_prog_err", bus0.Prog_Err, 0);
    end

    // full countdown of 6 with ticks 10 cycles apart
    step(1, 0, 0, 0, 0, 1, 0);
    chk("cd_start_busy", bus0.Busy, 1);
    chk("cd_start_rem", bus0.Remaining, 6);
    expcnt = 0;
    for (int t = 1; t <= 6; t++) begin
      for (int j = 0; j < 9; j++) begin
        step(1, 0, 0, 0, 0, 0, 0);
        expcnt += int'(bus0.Expired);
      end
      step(1, 0, 0, 0, 0, 0, 1);
      expcnt += int'(bus0.Expired);
      chk("cd_rem", bus0.Remaining, 6 - t);
      chk("cd_busy", bus0.Busy, (t < 6) ? 1 : 0);
      chk("cd_expired_edge", bus0.Expired, (t == 6) ? 1 : 0);
    end
    for (int j = 0; j < 5; j++) begin
      step(1, 0, 0, 0, 0, 0, 0);
      expcnt += int'(bus0.Expired);
    end
    chk("cd_expired_count", expcnt, 1);

    // restart at Remaining=2
    step(1, 0, 0, 0, 0, 1, 0);
    for (int j = 0; j < 4; j++) step(1, 0, 0, 0, 0, 0, 1);
    chk("rs_rem_before", bus0.Remaining, 2);
    step(1, 0, 0, 0, 0, 1, 0);
    chk("rs_rem_reload", bus0.Remaining, 6);
    chk("rs_no_expired", bus0.Expired, 0);
    step(0, 0, 0, 0, 0, 0, 0);

    // zero write to index 2
    step(1, 1, 2, 0, 2, 0, 0);
    chk("zw_prog_err", bus0.Prog_Err, GUARD ? 1 : 0);
    chk("zw_value", bus0.Value, GUARD ? 2 : 0);
    step(1, 0, 0, 0, 2, 1, 0);
    chk("zw_start_expired", bus0.Expired, GUARD ? 0 : 1);
    chk("zw_start_busy", bus0.Busy, GUARD ? 1 : 0);
    step(1, 0, 0, 0, 2, 0, 0);
    chk("zw_expired_width", bus0.Expired, 0);
    chk("zw_prog_err_width", bus0.Prog_Err, 0);
    step(0, 0, 0, 0, 0, 0, 0);

    // reset mid-countdown at Remaining=3
    step(1, 0, 0, 0, 0, 1, 0);
    for (int j = 0; j < 3; j++) step(1, 0, 0, 0, 0, 0, 1);
    chk("mr_rem_before", bus0.Remaining, 3);
    step(0, 0, 0, 0, 0, 0, 1);
    chk("mr_busy", bus0.Busy, 0);
    chk("mr_rem", bus0.Remaining, 0);
    chk("mr_expired", bus0.Expired, 0);

    // random traffic against the reference model
    for (int n = 0; n < 800; n++) begin
      step(($urandom_range(0, 49) != 0),
           ($urandom_range(0, 7) == 0),
           int'($urandom_range(0, 3)),
           int'($urandom_range(0, 15)),
           int'($urandom_range(0, 3)),
           ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 3) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
